// File: rtl/mem_access_cntrl.sv
// MEM-stage data-memory access controller: turns a load/store into a req/gnt/rvalid
// transaction, stalls the pipeline until it completes and returns lane-aligned load data.
module mem_access_cntrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lane_q;
  logic             req_q, we_q, done_q, mis_q, to_q;
  logic [3:0]       be_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             mem_op, misaligned, expired;

  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   be_f = 4'b0001 << lane;
      2'b01:   be_f = 4'b0011 << {lane[1], 1'b0};
      default: be_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   wdata_f = {4{wd[7:0]}};
      2'b01:   wdata_f = {2{wd[15:0]}};
      default: wdata_f = wd;
    endcase
  endfunction

  function automatic logic mis_f(input logic [1:0] size, input logic [1:0] lane);
    mis_f = ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

  assign mem_op     = valid_i & (is_load_i | is_store_i) & ~flush_i;
  assign misaligned = mis_f(size_i, addr_i[1:0]);
  // Counter covers REQ and WAIT together; >= keeps a late grant from escaping the budget.
  assign expired    = (cnt_q >= CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              mis_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= is_store_i;
              be_q    <= be_f(size_i, addr_i[1:0]);
              addr_q  <= {addr_i[31:2], 2'b00};
              wdata_q <= is_store_i ? wdata_f(size_i, wdata_i) : '0;
              lane_q  <= addr_i[1:0];
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_gnt_i) begin
            req_q <= 1'b0;
            if (flush_i) begin
              state_q <= we_q ? S_IDLE : S_DRAIN;
            end else if (we_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (flush_i) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (expired) begin
            req_q   <= 1'b0;
            state_q <= S_IDLE;
            to_q    <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_rvalid_i) begin
            state_q <= flush_i ? S_IDLE : S_DONE;
            if (!flush_i) begin
              rdata_q <= dmem_rdata_i >> {lane_q, 3'b000};
              done_q  <= 1'b1;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end else if (expired) begin
            state_q <= S_IDLE;
            to_q    <= 1'b1;
            rdata_q <= '0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_DRAIN: if (dmem_rvalid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:                  stall_o = mem_op & ~misaligned;
      S_REQ, S_WAIT, S_DRAIN:  stall_o = 1'b1;
      default:                 stall_o = 1'b0;
    endcase
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;
  assign timeout_o    = to_q;

endmodule

// File: tb/tb_mem_access_cntrl.sv
// Scoreboard bench for mem_access_cntrl: directed scenarios plus randomized loads/stores
// against an outcome-level reference model.
module tb_mem_access_cntrl;
  localparam int MAX_WAIT = 16;
  localparam logic [2:0] K_DONE = 3'b100, K_MIS = 3'b010, K_TO = 3'b001, K_NONE = 3'b000;

  logic        clk = 1'b0;
  logic        rst_ni, valid_i, is_load_i, is_store_i, flush_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, rdata_o;
  logic        stall_o, done_o, misaligned_o, timeout_o;

  typedef struct { logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; logic we; } req_t;
  typedef struct { logic [2:0] kind; logic [31:0] rdata; } rsp_t;
  req_t req_exp[$];
  rsp_t rsp_exp[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;
  logic prev_req = 1'b0;

  mem_access_cntrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: request fields while req is up, and one response per completion pulse.
  always @(negedge clk) begin
    rsp_t e;
    if (dmem_req_o === 1'b1) begin
      if (req_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req actual=1 expected=0");
      end else begin
        chk("req_be",    32'(dmem_be_o),    32'(req_exp[0].be));
        chk("req_addr",  dmem_addr_o,       req_exp[0].addr);
        chk("req_wdata", dmem_wdata_o,      req_exp[0].wdata);
        chk("req_we",    32'(dmem_we_o),    32'(req_exp[0].we));
      end
    end
    if (prev_req && dmem_req_o !== 1'b1 && req_exp.size() > 0) void'(req_exp.pop_front());
    prev_req = (dmem_req_o === 1'b1);
    if (done_o === 1'b1 || misaligned_o === 1'b1 || timeout_o === 1'b1) begin
      if (rsp_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse actual=%b expected=000", {done_o, misaligned_o, timeout_o});
      end else begin
        e = rsp_exp.pop_front();
        chk("resp_kind", 32'({done_o, misaligned_o, timeout_o}), 32'(e.kind));
        if (e.kind != K_MIS) chk("resp_rdata", rdata_o, e.rdata);
      end
    end
  end

  // One MEM-stage access. gd: REQ cycles before gnt; rd: WAIT cycles before rvalid;
  // fl: 0 none, 1 flush in REQ, 2 flush in first WAIT cycle.
  task automatic txn(input bit st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input int gd, input int rd, input logic [31:0] rdat, input int fl);
    int lane, exp_cyc, ridx, w, cyc;
    bit mis, granted, fin;
    logic [2:0] kind;
    req_t r;
    rsp_t s;
    lane = int'(a % 4);
    mis  = (sz == 2'd1 && lane % 2 != 0) || (sz >= 2'd2 && lane != 0);
    if (mis) begin
      kind = K_MIS; exp_cyc = 2;
    end else if (fl == 1) begin
      kind = K_NONE; exp_cyc = 3;
    end else if (fl == 2) begin
      kind = K_NONE; exp_cyc = gd + rd + 4;
    end else if (gd > MAX_WAIT - 1 || (!st && gd + 1 + rd > MAX_WAIT - 1)) begin
      kind = K_TO; exp_cyc = MAX_WAIT + 2; last_rdata = '0;
    end else begin
      kind = K_DONE; exp_cyc = st ? gd + 3 : gd + rd + 4;
      if (!st) last_rdata = rdat >> (8 * lane);
    end
    if (kind != K_NONE) begin
      s.kind = kind; s.rdata = last_rdata;
      rsp_exp.push_back(s);
    end
    if (!mis) begin
      case (sz)
        2'd0:    r.be = 4'(1 << lane);
        2'd1:    r.be = 4'(3 << (lane & 2));
        default: r.be = 4'hF;
      endcase
      r.addr = a - 32'(lane);
      r.we   = st;
      if (!st)            r.wdata = '0;
      else if (sz == 2'd0) r.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (sz == 2'd1) r.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      else                 r.wdata = wd;
      req_exp.push_back(r);
    end
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = ~st; is_store_i = st; size_i = sz; addr_i = a; wdata_i = wd;
    flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("stall_cycle1", 32'(stall_o), 32'(!mis));
    granted = 0; ridx = 0; w = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      valid_i = 1'b0; flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      dmem_rdata_i = $urandom;
      if (!granted) begin
        if (dmem_req_o) begin
          if (fl == 1) flush_i = 1'b1;
          else if (ridx == gd) begin dmem_gnt_i = 1'b1; granted = 1; end
          else ridx++;
        end
      end else if (!st) begin
        if (w == 0 && fl == 2) flush_i = 1'b1;
        if (w == rd) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdat; end
        w++;
      end
      @(negedge clk);
      if (granted && !dmem_gnt_i) chk("req_low_after_gnt", 32'(dmem_req_o), 32'd0);
      fin = !stall_o;
    end
    chk("latency", 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0] sz;
    bit st;
    int gd, rd;
    req_t r;
    rst_ni = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; flush_i = 1'b0;
    size_i = '0; addr_i = '0; wdata_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req_o), 0);     chk("rst_we", 32'(dmem_we_o), 0);
    chk("rst_be", 32'(dmem_be_o), 0);       chk("rst_addr", dmem_addr_o, 0);
    chk("rst_wdata", dmem_wdata_o, 0);      chk("rst_done", 32'(done_o), 0);
    chk("rst_rdata", rdata_o, 0);           chk("rst_mis", 32'(misaligned_o), 0);
    chk("rst_to", 32'(timeout_o), 0);       chk("rst_stall", 32'(stall_o), 0);

    txn(0, 2'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    txn(1, 2'd0, 32'h203, 32'h5A, 3, 0, 32'h0, 0);
    txn(0, 2'd1, 32'h102, 32'hFFFF_FFFF, 0, 0, 32'h12345678, 0);
    txn(0, 2'd2, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    txn(0, 2'd1, 32'h103, 32'h0, 0, 0, 32'h0, 0);
    txn(0, 2'd2, 32'h200, 32'h0, 0, 30, 32'hCAFE_F00D, 0);
    txn(0, 2'd0, 32'h301, 32'h0, 1, 2, 32'hA5A5_1234, 2);
    txn(1, 2'd2, 32'h400, 32'h1111_2222, 5, 0, 32'h0, 1);
    txn(0, 2'd0, 32'h502, 32'h0, 0, 14, 32'h00AB_0000, 0);
    txn(0, 2'd2, 32'h504, 32'h0, 0, 15, 32'h1, 0);
    txn(0, 2'd3, 32'h508, 32'h0, 3, 11, 32'h8765_4321, 0);
    txn(1, 2'd1, 32'h60E, 32'hBEEF, 15, 0, 32'h0, 0);
    txn(1, 2'd2, 32'h610, 32'h7, 16, 0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      gd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : 20;
      rd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : 20;
      txn(st, sz, a, wd, gd, rd, $urandom, 0);
    end

    // Reset while a request is outstanding.
    r.be = 4'hF; r.addr = 32'h700; r.wdata = '0; r.we = 1'b0;
    req_exp.push_back(r);
    @(posedge clk); #1;
    valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; size_i = 2'd2; addr_i = 32'h700;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("req_before_reset", 32'(dmem_req_o), 1);
    rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    last_rdata = '0;
    chk("mid_rst_req", 32'(dmem_req_o), 0);   chk("mid_rst_be", 32'(dmem_be_o), 0);
    chk("mid_rst_addr", dmem_addr_o, 0);      chk("mid_rst_rdata", rdata_o, 0);
    chk("mid_rst_stall", 32'(stall_o), 0);    chk("mid_rst_done", 32'(done_o), 0);
    txn(1, 2'd2, 32'h800, 32'h1234_5678, 0, 0, 32'h0, 0);

    @(negedge clk);
    chk("rsp_queue_empty", 32'(rsp_exp.size()), 0);
    chk("req_queue_empty", 32'(req_exp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
